// File: rtl/instr_sequencer_pkg.sv
// Shared constants for the instruction sequencer: state codes seen by the
// datapath and the opcode values the sequencer has to recognise.
package instr_sequencer_pkg;

   typedef enum logic [3:0] {
      STATE_IDLE   = 4'd0,
      STATE_FETCH0 = 4'd1,
      STATE_LATCH0 = 4'd2,
      STATE_FETCH1 = 4'd3,
      STATE_LATCH1 = 4'd4,
      STATE_EXEC   = 4'd5,
      STATE_HALT   = 4'd6
   } state_t;

   localparam logic [7:0] OP_LIMM16 = 8'h02;
   localparam logic [7:0] OP_CP     = 8'h03;
   localparam logic [7:0] OP_OR     = 8'h10;
   localparam logic [7:0] OP_XOR    = 8'h11;
   localparam logic [7:0] OP_AND    = 8'h12;
   localparam logic [7:0] OP_ADD    = 8'h14;
   localparam logic [7:0] OP_SUB    = 8'h15;
   localparam logic [7:0] OP_SHL    = 8'h18;
   localparam logic [7:0] OP_SAR    = 8'h19;
   localparam logic [7:0] OP_LIMM32 = 8'hD0;
   localparam logic [7:0] OP_CPDR   = 8'hFD;
   localparam logic [7:0] OP_END    = 8'hFF;

endpackage

// File: rtl/instr_sequencer_if.sv
// Instruction memory bus: registered word address out, read data back.
interface instr_sequencer_if #(parameter int PC_WIDTH = 10);

   logic [PC_WIDTH-1:0] imem_addr;
   logic [31:0]         imem_data;

   modport master (output imem_addr, input imem_data);
   modport slave  (input imem_addr, output imem_data);

endinterface

// File: rtl/instr_sequencer_opcode_decoder.sv
// Combinational opcode classifier used by the sequencer for fetch length,
// termination, legality and debug capture.
module opcode_decoder
   import instr_sequencer_pkg::*;
(
   input  logic [7:0] opcode,
   output logic       is_two_word,
   output logic       is_end,
   output logic       is_legal,
   output logic       is_cpdr
);

   always_comb begin
      is_two_word = (opcode == OP_LIMM32);
      is_end      = (opcode == OP_END);
      is_cpdr     = (opcode == OP_CPDR);
      is_legal    = 1'b0;
      case (opcode)
         OP_LIMM16, OP_CP, OP_OR, OP_XOR, OP_AND, OP_ADD, OP_SUB,
         OP_SHL, OP_SAR, OP_LIMM32, OP_CPDR, OP_END: is_legal = 1'b1;
         default:                                    is_legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/instr_sequencer.sv
// Control unit for the integer datapath: fetches one- or two-word
// instructions, presents a single EXEC cycle per instruction, captures CPDR.
module instr_sequencer
   import instr_sequencer_pkg::*;
#(
   parameter int PC_WIDTH = 10,
   parameter int START_PC = 0
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start,
   input  logic                stop,
   instr_sequencer_if.master   imem,
   output logic [31:0]         instr0,
   output logic [31:0]         instr1,
   output logic [3:0]          current_state,
   input  logic [31:0]         ireg_d0,
   output logic [PC_WIDTH-1:0] pc,
   output logic [31:0]         dr,
   output logic                dr_valid,
   output logic                busy,
   output logic                halted,
   output logic                err
);

   localparam logic [PC_WIDTH-1:0] START_ADDR = PC_WIDTH'(START_PC);

   state_t     state;
   state_t     next_state;
   logic [7:0] dec_opcode;
   logic       is_two_word;
   logic       is_end;
   logic       is_legal;
   logic       is_cpdr;

   // One decoder serves both the fresh word in LATCH0 and the held word in EXEC.
   assign dec_opcode = (state == STATE_LATCH0) ? imem.imem_data[31:24] : instr0[31:24];

   opcode_decoder u_decoder (
      .opcode      (dec_opcode),
      .is_two_word (is_two_word),
      .is_end      (is_end),
      .is_legal    (is_legal),
      .is_cpdr     (is_cpdr)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= STATE_IDLE;
      else          state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         STATE_IDLE, STATE_HALT: if (start) next_state = STATE_FETCH0;
         STATE_FETCH0:           next_state = STATE_LATCH0;
         STATE_LATCH0: begin
            if (!is_legal || is_end) next_state = STATE_HALT;
            else if (is_two_word)    next_state = STATE_FETCH1;
            else                     next_state = STATE_EXEC;
         end
         STATE_FETCH1:           next_state = STATE_LATCH1;
         STATE_LATCH1:           next_state = STATE_EXEC;
         STATE_EXEC:             next_state = stop ? STATE_IDLE : STATE_FETCH0;
         default:                next_state = STATE_IDLE;
      endcase
   end

   // instr1 is deliberately left untouched by one-word instructions.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc             <= START_ADDR;
         imem.imem_addr <= START_ADDR;
         instr0         <= 32'd0;
         instr1         <= 32'd0;
         dr             <= 32'd0;
         dr_valid       <= 1'b0;
         err            <= 1'b0;
      end else begin
         dr_valid <= 1'b0;
         case (state)
            STATE_IDLE, STATE_HALT: begin
               if (start) begin
                  pc  <= START_ADDR;
                  err <= 1'b0;
               end
            end
            STATE_FETCH0, STATE_FETCH1: imem.imem_addr <= pc;
            STATE_LATCH0: begin
               instr0 <= imem.imem_data;
               pc     <= pc + PC_WIDTH'(1);
               if (!is_legal) err <= 1'b1;
            end
            STATE_LATCH1: begin
               instr1 <= imem.imem_data;
               pc     <= pc + PC_WIDTH'(1);
            end
            STATE_EXEC: begin
               if (is_cpdr) begin
                  dr       <= ireg_d0;
                  dr_valid <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign current_state = state;
   assign busy          = (state != STATE_IDLE) && (state != STATE_HALT);
   assign halted        = (state == STATE_HALT);

endmodule
